// File: rtl/beta_if_stage_pkg.sv
// Shared types and constants for the beta instruction fetch stage.
package beta_if_stage_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } if_state_t;

    localparam int INSTR_BYTES = 4;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/beta_if_stage_if.sv
// Instruction-memory request/grant/valid port of the fetch stage.
interface beta_if_stage_if #(
    parameter int DataWidth = 32
) ();

    logic                 req;
    logic [DataWidth-1:0] addr;
    logic                 gnt;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/beta_pc_gen.sv
// Program counter with +4 increment, pending-redirect register and target alignment check.
module beta_pc_gen
    import beta_if_stage_pkg::*;
#(
    parameter int                   DataWidth = 32,
    parameter logic [DataWidth-1:0] BootAddr  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_advance,
    input  logic                 i_redirect,
    input  logic [DataWidth-1:0] i_target,
    output logic [DataWidth-1:0] o_pc,
    output logic [DataWidth-1:0] o_next_pc,
    output logic                 o_pending,
    output logic                 o_fault
);

    logic [DataWidth-1:0] r_pc;
    logic [DataWidth-1:0] r_pend_tgt;
    logic                 r_pend_vld;
    logic [DataWidth-1:0] w_tgt;
    logic                 w_have_tgt;

    // A redirect arriving this cycle supersedes any older pending target.
    assign w_tgt      = i_redirect ? i_target : r_pend_tgt;
    assign w_have_tgt = i_redirect | r_pend_vld;

    assign o_pc      = r_pc;
    assign o_next_pc = r_pc + DataWidth'(INSTR_BYTES);
    assign o_pending = r_pend_vld;
    assign o_fault   = w_have_tgt & ~is_aligned(w_tgt[1:0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc       <= BootAddr;
            r_pend_vld <= 1'b0;
        end else if (i_advance) begin
            r_pc       <= w_have_tgt ? w_tgt : o_next_pc;
            r_pend_vld <= 1'b0;
        end else if (i_redirect) begin
            r_pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_redirect && !i_advance) begin
            r_pend_tgt <= i_target;
        end
    end

endmodule

// File: rtl/beta_if_stage.sv
// Instruction fetch stage: fetch FSM, instruction/next-PC registers and redirect handling.
module beta_if_stage
    import beta_if_stage_pkg::*;
#(
    parameter int                   DataWidth = 32,
    parameter logic [DataWidth-1:0] BootAddr  = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    beta_if_stage_if.master      imem,
    output logic [DataWidth-1:0] if_instr_o,
    output logic                 if_new_instr_o,
    output logic [DataWidth-1:0] if_next_pc_o,
    input  logic                 if_ready_i,
    input  logic                 if_jump_en_i,
    input  logic [DataWidth-1:0] if_jump_target_i,
    output logic                 if_fetch_fault_o,
    output logic                 if_stage_busy_o
);

    if_state_t            r_state;
    if_state_t            w_state_nxt;
    logic                 r_discard;
    logic                 w_discard_nxt;
    logic                 r_stale;
    logic                 r_new_instr;
    logic                 r_fault;
    logic                 r_busy;
    logic [DataWidth-1:0] r_instr;
    logic [DataWidth-1:0] r_next_pc;

    logic [DataWidth-1:0] w_pc;
    logic [DataWidth-1:0] w_pc_plus4;
    logic                 w_pending;
    logic                 w_fault;
    logic                 w_advance;
    logic                 w_deliver;
    logic                 w_rsp;
    logic                 w_done;
    logic                 w_drop;
    logic                 w_inflight;

    beta_pc_gen #(
        .DataWidth (DataWidth),
        .BootAddr  (BootAddr)
    ) u_pc_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_advance  (w_advance),
        .i_redirect (if_jump_en_i),
        .i_target   (if_jump_target_i),
        .o_pc       (w_pc),
        .o_next_pc  (w_pc_plus4),
        .o_pending  (w_pending),
        .o_fault    (w_fault)
    );

    // A response owed to a transaction abandoned by reset is swallowed before anything else.
    assign w_rsp      = imem.rvalid & ~r_stale;
    assign w_done     = w_rsp & (((r_state == REQ) & imem.gnt) | (r_state == WAIT));
    assign w_drop     = r_discard | w_pending | if_jump_en_i;
    assign w_inflight = ((r_state == WAIT) | ((r_state == REQ) & imem.gnt)) & ~w_rsp;

    assign imem.req  = (r_state == REQ);
    assign imem.addr = w_pc;

    always_comb begin
        w_state_nxt   = r_state;
        w_advance     = 1'b0;
        w_deliver     = 1'b0;
        w_discard_nxt = r_discard;
        unique case (r_state)
            IDLE: begin
                w_advance   = if_jump_en_i;
                w_state_nxt = (if_jump_en_i && w_fault) ? FAULT : REQ;
            end
            REQ: begin
                if (imem.gnt) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (if_jump_en_i) begin
                    w_discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                w_advance = if_jump_en_i;
                if (if_jump_en_i && w_fault) begin
                    w_state_nxt = FAULT;
                end else if (if_ready_i) begin
                    w_state_nxt = REQ;
                end
            end
            FAULT: begin
                w_advance = if_jump_en_i & ~w_fault;
                if (w_advance) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Completion moves the PC either to PC+4 or to the redirect target that killed the fetch.
        if (w_done) begin
            w_advance     = 1'b1;
            w_deliver     = ~w_drop;
            w_discard_nxt = 1'b0;
            if (w_fault) begin
                w_state_nxt = FAULT;
            end else if (w_drop) begin
                w_state_nxt = REQ;
            end else begin
                w_state_nxt = HOLD;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_discard   <= 1'b0;
            r_stale     <= (r_stale & ~imem.rvalid) | w_inflight;
            r_new_instr <= 1'b0;
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
            r_instr     <= '0;
            r_next_pc   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_discard   <= w_discard_nxt;
            r_stale     <= r_stale & ~imem.rvalid;
            r_new_instr <= w_deliver;
            r_fault     <= (w_state_nxt == FAULT);
            r_busy      <= (w_state_nxt == REQ) | (w_state_nxt == WAIT) | (r_stale & ~imem.rvalid);
            if (w_deliver) begin
                r_instr   <= imem.rdata;
                r_next_pc <= w_pc_plus4;
            end
        end
    end

    assign if_instr_o       = r_instr;
    assign if_new_instr_o   = r_new_instr;
    assign if_next_pc_o     = r_next_pc;
    assign if_fetch_fault_o = r_fault;
    assign if_stage_busy_o  = r_busy;

endmodule

// File: tb/tb_beta_if_stage.sv
// Cycle-by-cycle vector bench for beta_if_stage with BootAddr = 0x100.
module tb_beta_if_stage;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        jmp;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_new;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_flt;
        logic        e_bsy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ready;
    logic        if_jump_en;
    logic [31:0] if_jump_target;
    logic [31:0] if_instr;
    logic        if_new_instr;
    logic [31:0] if_next_pc;
    logic        if_fetch_fault;
    logic        if_stage_busy;

    int tests = 0;
    int fails = 0;

    beta_if_stage_if #(.DataWidth(32)) imem ();

    beta_if_stage #(
        .DataWidth (32),
        .BootAddr  (32'h0000_0100)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem             (imem),
        .if_instr_o       (if_instr),
        .if_new_instr_o   (if_new_instr),
        .if_next_pc_o     (if_next_pc),
        .if_ready_i       (if_ready),
        .if_jump_en_i     (if_jump_en),
        .if_jump_target_i (if_jump_target),
        .if_fetch_fault_o (if_fetch_fault),
        .if_stage_busy_o  (if_stage_busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rs, input logic g, input logic r, input logic [31:0] d,
        input logic rd, input logic j, input logic [31:0] t,
        input logic q, input logic [31:0] a, input logic n, input logic [31:0] ins,
        input logic [31:0] np, input logic f, input logic b);
        vec_t v;
        v.rst = rs; v.gnt = g; v.rv = r; v.rdata = d; v.rdy = rd; v.jmp = j; v.tgt = t;
        v.e_req = q; v.e_addr = a; v.e_new = n; v.e_instr = ins; v.e_npc = np;
        v.e_flt = f; v.e_bsy = b;
        return v;
    endfunction

    // Inputs for cycle are driven at negedge; outputs of that cycle are compared 1 ns later.
    task automatic apply(input vec_t v, input string nm);
        logic [99:0] act;
        logic [99:0] exp;
        @(negedge clk);
        rst            = v.rst;
        imem.gnt       = v.gnt;
        imem.rvalid    = v.rv;
        imem.rdata     = v.rdata;
        if_ready       = v.rdy;
        if_jump_en     = v.jmp;
        if_jump_target = v.tgt;
        #1;
        act = {imem.req, imem.addr, if_new_instr, if_instr, if_next_pc, if_fetch_fault, if_stage_busy};
        exp = {v.e_req, v.e_addr, v.e_new, v.e_instr, v.e_npc, v.e_flt, v.e_bsy};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got req=%b addr=%h new=%b instr=%h npc=%h flt=%b bsy=%b, want req=%b addr=%h new=%b instr=%h npc=%h flt=%b bsy=%b",
                     nm, act[99], act[98:67], act[66], act[65:34], act[33:2], act[1], act[0],
                     exp[99], exp[98:67], exp[66], exp[65:34], exp[33:2], exp[1], exp[0]);
        end
    endtask

    localparam logic [31:0] I0 = 32'h0050_0093;
    localparam logic [31:0] I1 = 32'h00a0_0113;
    localparam logic [31:0] I2 = 32'h0000_0013;
    localparam logic [31:0] I3 = 32'h2222_2222;
    localparam logic [31:0] I4 = 32'h3333_3333;

    vec_t vecs[$];

    initial begin
        rst = 1'b1; imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        if_ready = 1'b0; if_jump_en = 1'b0; if_jump_target = '0;
        repeat (2) @(posedge clk);

        vecs.push_back(mk(1,0,0,0,0,0,0,             0,32'h100,0,0,0,0,0));
        // Boot fetch: req at t, rvalid at t+1, pulse at t+2.
        vecs.push_back(mk(0,0,0,0,0,0,0,             0,32'h100,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,             1,32'h100,0,0,0,0,1));
        vecs.push_back(mk(0,0,1,I0,0,0,0,            0,32'h100,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,             0,32'h104,1,I0,32'h104,0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0,         0,32'h104,0,I0,32'h104,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,             0,32'h104,0,I0,32'h104,0,0));
        // Grant withheld for three cycles: address must not move.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0,         1,32'h104,0,I0,32'h104,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,0,             1,32'h104,0,I0,32'h104,0,1));
        // Redirect in WAIT drops the in-flight response.
        vecs.push_back(mk(0,0,0,0,0,1,32'h200,       0,32'h104,0,I0,32'h104,0,1));
        vecs.push_back(mk(0,0,1,32'hDEADBEEF,0,0,0,  0,32'h104,0,I0,32'h104,0,1));
        vecs.push_back(mk(0,1,1,I1,0,0,0,            1,32'h200,0,I0,32'h104,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,             0,32'h204,1,I1,32'h204,0,0));
        // Redirect in REQ before grant.
        vecs.push_back(mk(0,0,0,0,0,1,32'h300,       1,32'h204,0,I1,32'h204,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,0,             1,32'h204,0,I1,32'h204,0,1));
        vecs.push_back(mk(0,0,1,32'h11111111,0,0,0,  0,32'h204,0,I1,32'h204,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,0,             1,32'h300,0,I1,32'h204,0,1));
        vecs.push_back(mk(0,0,1,I2,0,0,0,            0,32'h300,0,I1,32'h204,0,1));
        // Misaligned redirect in HOLD, then misaligned again in FAULT, then aligned exit.
        vecs.push_back(mk(0,0,0,0,0,1,32'h202,       0,32'h304,1,I2,32'h304,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,             0,32'h202,0,I2,32'h304,1,0));
        vecs.push_back(mk(0,0,0,0,1,1,32'h302,       0,32'h202,0,I2,32'h304,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h400,       0,32'h202,0,I2,32'h304,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,             1,32'h400,0,I2,32'h304,0,1));
        vecs.push_back(mk(0,0,1,I3,0,0,0,            0,32'h400,0,I2,32'h304,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,             0,32'h404,1,I3,32'h404,0,0));
        // Misaligned redirect while a fetch is outstanding: fault only after it drains.
        vecs.push_back(mk(0,1,0,0,0,1,32'h403,       1,32'h404,0,I3,32'h404,0,1));
        vecs.push_back(mk(0,0,1,32'h99999999,0,0,0,  0,32'h404,0,I3,32'h404,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,32'hFFFFFFFC,  0,32'h403,0,I3,32'h404,1,0));
        // Fetch at top of address space wraps next-PC to zero.
        vecs.push_back(mk(0,1,1,I4,0,0,0,            1,32'hFFFFFFFC,0,I3,32'h404,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,             0,32'h0,1,I4,32'h0,0,0));
        // Redirect coincident with rvalid drops the response.
        vecs.push_back(mk(0,1,0,0,0,0,0,             1,32'h0,0,I4,32'h0,0,1));
        vecs.push_back(mk(0,0,1,32'h44444444,0,1,32'h500, 0,32'h0,0,I4,32'h0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,0,             1,32'h500,0,I4,32'h0,0,1));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Reset while WAIT; the late response for the abandoned fetch lands with the new grant.
        apply(mk(1,0,0,0,0,0,0,                      0,32'h500,0,I4,32'h0,0,1), "rst_in_wait");
        apply(mk(0,0,0,0,0,0,0,                      0,32'h100,0,0,0,0,0), "after_rst");
        apply(mk(0,1,1,32'h55555555,0,0,0,           1,32'h100,0,0,0,0,1), "stale_rvalid");
        apply(mk(0,0,1,32'h66666666,0,0,0,           0,32'h100,0,0,0,0,1), "real_wait");
        apply(mk(0,0,0,0,0,0,0,                      0,32'h104,1,32'h66666666,32'h104,0,0), "real_deliver");
        apply(mk(0,0,0,0,0,0,0,                      0,32'h104,0,32'h66666666,32'h104,0,0), "pulse_once");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/beta_if_stage.md
# beta_if_stage

Instruction fetch stage, first in the pipe, directly upstream of the decode stage. Owns the program counter and drives a request/grant/valid instruction-memory port. Hands decode one 32-bit instruction at a time: a single-cycle new-instruction pulse plus a stable instruction word and next-PC. Accepts control-flow redirects from the execute stage and discards any fetch that a redirect has made stale.

## Interface
- DataWidth, 32, width of PC, addresses and instruction word (only 32 supported)
- BootAddr, 32'h0000_0000, PC value after reset
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- imem_req_o  out  1  fetch request; held until granted
- imem_addr_o  out  DataWidth  fetch address; stable while imem_req_o=1 and not granted
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  DataWidth  response instruction word
- if_instr_o  out  DataWidth  fetched instruction, held until the next delivery
- if_new_instr_o  out  1  one-cycle pulse: new if_instr_o/if_next_pc_o valid
- if_next_pc_o  out  DataWidth  PC of delivered instruction + 4
- if_ready_i  in  1  downstream may accept the next instruction (decode and execute not busy)
- if_jump_en_i  in  1  redirect pulse from execute
- if_jump_target_i  in  DataWidth  redirect target
- if_fetch_fault_o  out  1  misaligned redirect target; level, held until the next valid redirect
- if_stage_busy_o  out  1  a fetch transaction is outstanding

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE (reset state) -> REQ on the next cycle, with the PC at BootAddr.
- REQ:
  - imem_req_o=1, imem_addr_o=PC.
  - On imem_gnt_i -> WAIT.
  - If imem_rvalid_i arrives in the same cycle as imem_gnt_i, the response is captured and the FSM goes directly to HOLD.
- WAIT: on imem_rvalid_i, capture imem_rdata_i into if_instr_o, set if_next_pc_o = PC+4 and PC <= PC+4 (modulo 2^32, wraps silently), then -> HOLD.
- HOLD:
  - if_new_instr_o=1 in the first HOLD cycle only.
  - When if_ready_i=1 (including in the first HOLD cycle) -> REQ.
- Redirect (if_jump_en_i=1):
  - Target latched into a pending-redirect register; takes priority over PC+4.
  - In IDLE/HOLD: PC <= target; in HOLD, the next REQ uses the target.
  - In REQ before grant: address is not changed. The transaction completes, its response is discarded (no pulse, if_instr_o unchanged), then the FSM goes to REQ at the target.
  - In WAIT: a discard flag is set; the arriving response is dropped, then REQ at the target.
  - Simultaneous redirect and rvalid: the response is dropped.
  - A second redirect before the first is consumed overwrites the pending target.
- Misaligned target (target[1:0] != 0):
  - FSM -> FAULT after any outstanding transaction drains.
  - if_fetch_fault_o=1; no requests issued.
  - FAULT exits only on an aligned redirect, to REQ.
- Busy: if_stage_busy_o=1 in REQ and WAIT, and while a discarded transaction drains.

## Timing
- Reset values:
  - imem_req_o=0, imem_addr_o=BootAddr, if_instr_o=0, if_next_pc_o=0.
  - if_new_instr_o=0, if_fetch_fault_o=0, if_stage_busy_o=0.
  - PC=BootAddr; pending redirect and discard flag cleared.
- rst_i mid-transaction abandons it; a response arriving after reset is ignored (discard flag set on reset while not in IDLE).
- Best-case latency, with gnt in the request cycle and rvalid one cycle later: req at cycle t, rvalid at t+1, if_new_instr_o at t+2.
- Throughput with if_ready_i held at 1: one instruction per 3 cycles (HOLD -> REQ same edge the pulse is seen).
- All outputs are registered except imem_req_o and imem_addr_o, which decode from state and PC registers only (no combinational path from inputs).

## Structure
- Package beta_if_stage_pkg holds:
  - typedef enum logic[2:0] if_state_t {IDLE, REQ, WAIT, HOLD, FAULT}
  - localparam INSTR_BYTES = 4
- One sub-module, beta_pc_gen, holds the PC register, PC+4 adder, pending-redirect register and misalignment check. Inputs: advance, redirect, target. Outputs: pc, next_pc, pending, fault.
- The FSM and the instruction register live in beta_if_stage.

## Test plan
- Reset release, BootAddr=0x100, gnt immediate, rvalid next cycle, rdata=0x00500093 -> imem_addr_o=0x100, if_new_instr_o pulses at t+2, if_instr_o=0x00500093, if_next_pc_o=0x104.
- if_ready_i low 5 cycles in HOLD -> no new request, if_new_instr_o only one cycle, if_instr_o stable; after ready rises, request at addr 0x104.
- gnt delayed 3 cycles -> imem_addr_o stable through all wait cycles, single transaction.
- Redirect to 0x200 during WAIT -> response dropped (no pulse), next request addr=0x200, delivered if_next_pc_o=0x204.
- Redirect to 0x202 -> if_fetch_fault_o=1, no further imem_req_o; then redirect to 0x300 -> fault clears, fetch at 0x300.
- PC=0xFFFFFFFC fetch -> if_next_pc_o=0x00000000; rst_i asserted in WAIT with late rvalid -> no pulse, restart at BootAddr.
